id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV64 core (IF/ID/EX/MEM/WB) around id_stage.
//  Shadows the in-flight destination registers of EX/MEM/WB and detects RAW hazards against the
//  rs1/rs2 read enables and addresses that id_stage decodes. Produces per-operand forwarding
//  selects, load-use and CSR stalls, redirect flushes, pipeline freeze and stall/flush perf counters.
// PARAMETERS
//  RA_W   5   register address width
//  CNT_W  32  width of stall_cnt / flush_cnt (saturating)
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst           in   1      asynchronous, active-low reset (0 = reset)
//  id_valid      in   1      ID holds a valid instruction
//  id_rs1_r_ena  in   1      from id_stage rs1_r_ena
//  id_rs1_r_addr in   RA_W   from id_stage rs1_r_addr
//  id_rs2_r_ena  in   1      from id_stage rs2_r_ena
//  id_rs2_r_addr in   RA_W   from id_stage rs2_r_addr
//  id_rd_w_ena   in   1      from id_stage rd_w_ena
//  id_rd_w_addr  in   RA_W   from id_stage rd_w_addr
//  id_mem_rd_ena in   1      ID instruction is a load
//  id_csr_ena    in   1      ID instruction reads/writes a CSR (csr_rd_ena | csr_wr_ena)
//  ex_redirect   in   1      branch/jump in EX resolved to a new PC
//  mem_busy      in   1      data memory not done; freeze whole pipe
//  if_stall      out  1      hold PC and IF/ID register
//  id_flush      out  1      squash IF/ID contents (becomes bubble)
//  ex_bubble     out  1      load ID->EX register with a bubble
//  pipe_freeze   out  1      hold ID/EX, EX/MEM, MEM/WB registers
//  fwd_rs1_sel   out  2      0 regfile, 1 EX alu result, 2 MEM result, 3 WB result
//  fwd_rs2_sel   out  2      same encoding for rs2
//  stall_cnt     out  CNT_W  cycles with load-use or CSR stall asserted
//  flush_cnt     out  CNT_W  accepted redirects
// BEHAVIOUR
//  - Shadow entries EX/MEM/WB: {v, rd, ld, csr}; rd==0 or rd_w_ena==0 stored as v=0. Reset: all v=0,
//    counters 0. Outputs reset: if_stall=0, id_flush=0, ex_bubble=1, pipe_freeze=0, fwd_*=0.
//  - Advance per clk when pipe_freeze=0: WB<=MEM, MEM<=EX, EX<=(ex_bubble ? 0 : ID fields).
//  - pipe_freeze = mem_busy. While frozen: shadows, counters hold; if_stall=1, id_flush=0, ex_bubble=0.
//  - Match(s,rsX) = rsX_r_ena & rsX!=0 & s.v & s.rd==rsX. Priority EX > MEM > WB (youngest wins).
//  - ld_use = id_valid & (Match(EX,rs1)&EX.ld | Match(EX,rs2)&EX.ld).
//  - csr_hz = id_valid & id_csr_ena & (EX.csr | MEM.csr | WB.csr) (CSR ops serialize, no forwarding).
//  - fwd_rsX_sel: EX match & ~EX.ld -> 1; else MEM match -> 2 (MEM mux supplies load data); else WB -> 3;
//    else 0. Combinational, valid every cycle independent of stalls.
//  - Not frozen, ex_redirect=1: id_flush=1, ex_bubble=1, if_stall=0; hazards ignored; flush_cnt+1.
//  - Not frozen, no redirect, ld_use|csr_hz: if_stall=1, ex_bubble=1, id_flush=0; stall_cnt+1.
//  - Otherwise: all control 0, ex_bubble = ~id_valid.
//  - Load-use costs exactly 1 cycle; CSR hazard holds until EX/MEM/WB contain no CSR op (<=3 cycles).
//  - Counters saturate at all-ones, never wrap.
//  - rst assertion mid-stall/flush: immediate clear; first post-reset cycle EX/MEM/WB empty, no hazard.
// STRUCTURE
//  - defines.v: `FWD_BUS, `FWD_RF=0, `FWD_EX=1, `FWD_MEM=2, `FWD_WB=3; `HZ_ENT_BUS shadow entry layout.
//  - Sub-module hz_fwd_pick: one operand's 3-way match and priority encode; instantiated for rs1, rs2.
//  - Shadow regs and counters in top; all control outputs combinational from shadows + inputs.
// TESTING
//  - ld x5 in ID, then add x6,x5,x7: cycle 2 ld_use -> if_stall=1, ex_bubble=1 one cycle, then fwd_rs1_sel=2.
//  - addi x3,x0,1; addi x4,x3,1 back-to-back -> no stall, fwd_rs1_sel=1 for second.
//  - x3 written in EX and WB, ID reads x3 -> fwd_rs1_sel=1 (youngest); reads x0 with rd=0 -> 0.
//  - ex_redirect=1 coincident with ld_use -> id_flush=1, if_stall=0, flush_cnt+1, stall_cnt unchanged.
//  - mem_busy=1 for 4 cycles with ld_use pending -> pipe_freeze=1, shadows/counters hold, stall after release.
//  - csrrw in EX, csrrs in ID -> if_stall=1 for 3 cycles, stall_cnt=3; counter preset all-ones stays all-ones.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller: forwarding select encoding and control modes.
package id_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FwdRf  = 2'd0,
        FwdEx  = 2'd1,
        FwdMem = 2'd2,
        FwdWb  = 2'd3
    } fwd_sel_e;

    // Mutually exclusive pipeline control situations, in priority order.
    typedef enum logic [1:0] {
        CtlRun    = 2'd0,
        CtlFreeze = 2'd1,
        CtlFlush  = 2'd2,
        CtlStall  = 2'd3
    } ctl_mode_e;

endpackage

// File: rtl/id_hazard_ctrl_fwd_pick.sv
// One source operand: match against EX/MEM/WB destinations and pick the youngest forwarding source.
module id_hazard_ctrl_fwd_pick
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned RA_W = 5
) (
    input  logic            rs_ena_i,
    input  logic [RA_W-1:0] rs_addr_i,
    input  logic            ex_v_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            ex_ld_i,
    input  logic            mem_v_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            wb_v_i,
    input  logic [RA_W-1:0] wb_rd_i,
    output fwd_sel_e        sel_o,
    output logic            ld_use_o
);

    logic rs_live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        rs_live  = rs_ena_i & (rs_addr_i != '0);
        ex_hit   = rs_live & ex_v_i & (ex_rd_i == rs_addr_i);
        mem_hit  = rs_live & mem_v_i & (mem_rd_i == rs_addr_i);
        wb_hit   = rs_live & wb_v_i & (wb_rd_i == rs_addr_i);
        ld_use_o = ex_hit & ex_ld_i;

        // A load in EX has no data yet; fall through to older stages, the stall covers it.
        sel_o = FwdRf;
        if (ex_hit && !ex_ld_i) begin
            sel_o = FwdEx;
        end else if (mem_hit) begin
            sel_o = FwdMem;
        end else if (wb_hit) begin
            sel_o = FwdWb;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Pipeline sequencing around id_stage: shadows EX/MEM/WB destinations, resolves RAW hazards,
// drives stall/flush/freeze controls and counts stall cycles and accepted redirects.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs1_r_ena,
    input  logic [RA_W-1:0]  id_rs1_r_addr,
    input  logic             id_rs2_r_ena,
    input  logic [RA_W-1:0]  id_rs2_r_addr,
    input  logic             id_rd_w_ena,
    input  logic [RA_W-1:0]  id_rd_w_addr,
    input  logic             id_mem_rd_ena,
    input  logic             id_csr_ena,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             if_stall,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            ld;
        logic            csr;
    } hz_ent_t;

    hz_ent_t ex_q, ex_d;
    hz_ent_t mem_q, mem_d;
    hz_ent_t wb_q, wb_d;
    hz_ent_t id_ent;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    fwd_sel_e  rs1_sel, rs2_sel;
    logic      rs1_ld_use, rs2_ld_use;
    logic      ld_use, csr_hz;
    ctl_mode_e mode;

    id_hazard_ctrl_fwd_pick #(
        .RA_W (RA_W)
    ) u_pick_rs1 (
        .rs_ena_i  (id_rs1_r_ena),
        .rs_addr_i (id_rs1_r_addr),
        .ex_v_i    (ex_q.v),
        .ex_rd_i   (ex_q.rd),
        .ex_ld_i   (ex_q.ld),
        .mem_v_i   (mem_q.v),
        .mem_rd_i  (mem_q.rd),
        .wb_v_i    (wb_q.v),
        .wb_rd_i   (wb_q.rd),
        .sel_o     (rs1_sel),
        .ld_use_o  (rs1_ld_use)
    );

    id_hazard_ctrl_fwd_pick #(
        .RA_W (RA_W)
    ) u_pick_rs2 (
        .rs_ena_i  (id_rs2_r_ena),
        .rs_addr_i (id_rs2_r_addr),
        .ex_v_i    (ex_q.v),
        .ex_rd_i   (ex_q.rd),
        .ex_ld_i   (ex_q.ld),
        .mem_v_i   (mem_q.v),
        .mem_rd_i  (mem_q.rd),
        .wb_v_i    (wb_q.v),
        .wb_rd_i   (wb_q.rd),
        .sel_o     (rs2_sel),
        .ld_use_o  (rs2_ld_use)
    );

    // CSR ops serialize: any CSR op still in flight blocks a CSR op in ID.
    always_comb begin
        ld_use = id_valid & (rs1_ld_use | rs2_ld_use);
        csr_hz = id_valid & id_csr_ena & (ex_q.csr | mem_q.csr | wb_q.csr);
        if (mem_busy) begin
            mode = CtlFreeze;
        end else if (ex_redirect) begin
            mode = CtlFlush;
        end else if (ld_use || csr_hz) begin
            mode = CtlStall;
        end else begin
            mode = CtlRun;
        end
    end

    always_comb begin
        if_stall    = 1'b0;
        id_flush    = 1'b0;
        ex_bubble   = ~id_valid;
        pipe_freeze = 1'b0;
        fwd_rs1_sel = rs1_sel;
        fwd_rs2_sel = rs2_sel;
        unique case (mode)
            CtlFreeze: begin
                if_stall    = 1'b1;
                ex_bubble   = 1'b0;
                pipe_freeze = 1'b1;
            end
            CtlFlush: begin
                id_flush  = 1'b1;
                ex_bubble = 1'b1;
            end
            CtlStall: begin
                if_stall  = 1'b1;
                ex_bubble = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            if_stall    = 1'b0;
            id_flush    = 1'b0;
            ex_bubble   = 1'b1;
            pipe_freeze = 1'b0;
            fwd_rs1_sel = FwdRf;
            fwd_rs2_sel = FwdRf;
        end
    end

    // Writes to x0 or without rd_w_ena are never forwarding sources; ld/csr still tracked.
    always_comb begin
        id_ent.v   = id_rd_w_ena & (id_rd_w_addr != '0);
        id_ent.rd  = id_rd_w_addr;
        id_ent.ld  = id_mem_rd_ena;
        id_ent.csr = id_csr_ena;

        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (mode != CtlFreeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = ex_bubble ? '0 : id_ent;
        end
        if (mode == CtlStall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (mode == CtlFlush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl; a second instance with 2-bit counters exercises saturation.
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid, id_rs1_r_ena, id_rs2_r_ena, id_rd_w_ena, id_mem_rd_ena, id_csr_ena;
    logic [4:0]  id_rs1_r_addr, id_rs2_r_addr, id_rd_w_addr;
    logic        ex_redirect, mem_busy;
    logic        if_stall, id_flush, ex_bubble, pipe_freeze;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_if_stall, s_id_flush, s_ex_bubble, s_pipe_freeze;
    logic [1:0]  s_fwd_rs1_sel, s_fwd_rs2_sel;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    logic [3:0]  ctl, fwd;

    int total = 0;
    int bad   = 0;

    assign ctl = {if_stall, id_flush, ex_bubble, pipe_freeze};
    assign fwd = {fwd_rs1_sel, fwd_rs2_sel};

    always #5 clk = ~clk;

    id_hazard_ctrl #(.RA_W(5), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_r_ena(id_rs1_r_ena), .id_rs1_r_addr(id_rs1_r_addr),
        .id_rs2_r_ena(id_rs2_r_ena), .id_rs2_r_addr(id_rs2_r_addr),
        .id_rd_w_ena(id_rd_w_ena), .id_rd_w_addr(id_rd_w_addr),
        .id_mem_rd_ena(id_mem_rd_ena), .id_csr_ena(id_csr_ena),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .if_stall(if_stall), .id_flush(id_flush), .ex_bubble(ex_bubble),
        .pipe_freeze(pipe_freeze), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_hazard_ctrl #(.RA_W(5), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_r_ena(id_rs1_r_ena), .id_rs1_r_addr(id_rs1_r_addr),
        .id_rs2_r_ena(id_rs2_r_ena), .id_rs2_r_addr(id_rs2_r_addr),
        .id_rd_w_ena(id_rd_w_ena), .id_rd_w_addr(id_rd_w_addr),
        .id_mem_rd_ena(id_mem_rd_ena), .id_csr_ena(id_csr_ena),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .if_stall(s_if_stall), .id_flush(s_id_flush), .ex_bubble(s_ex_bubble),
        .pipe_freeze(s_pipe_freeze), .fwd_rs1_sel(s_fwd_rs1_sel), .fwd_rs2_sel(s_fwd_rs2_sel),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic set_id(input logic v, input logic r1e, input logic [4:0] r1,
                          input logic r2e, input logic [4:0] r2, input logic rde,
                          input logic [4:0] rd, input logic ld, input logic csr);
        id_valid      = v;
        id_rs1_r_ena  = r1e;
        id_rs1_r_addr = r1;
        id_rs2_r_ena  = r2e;
        id_rs2_r_addr = r2;
        id_rd_w_ena   = rde;
        id_rd_w_addr  = rd;
        id_mem_rd_ena = ld;
        id_csr_ena    = csr;
    endtask

    task automatic idle();
        set_id(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b1);
        #2;
        total++;
        if (ctl !== 4'b0010) begin
            bad++; $display("FAIL rst_ctl got=%b want=%b", ctl, 4'b0010);
        end
        total++;
        if (fwd !== 4'b0000) begin
            bad++; $display("FAIL rst_fwd got=%b want=%b", fwd, 4'b0000);
        end
        total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        idle();
        step();
        step();
        rst = 1'b1;
        #1;
        total++;
        if (ctl !== 4'b0010) begin
            bad++; $display("FAIL rst_idle_ctl got=%b want=%b", ctl, 4'b0010);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        total++;
        if (ctl !== 4'b0000) begin
            bad++; $display("FAIL lu_issue got=%b want=%b", ctl, 4'b0000);
        end
        step();
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0, 1'b0);
        #1;
        total++;
        if (ctl !== 4'b1010) begin
            bad++; $display("FAIL lu_stall got=%b want=%b", ctl, 4'b1010);
        end
        total++;
        if (fwd !== 4'b0000) begin
            bad++; $display("FAIL lu_fwd_stall got=%b want=%b", fwd, 4'b0000);
        end
        step();
        total++;
        if (ctl !== 4'b0000) begin
            bad++; $display("FAIL lu_release got=%b want=%b", ctl, 4'b0000);
        end
        total++;
        if (fwd !== 4'b1000) begin
            bad++; $display("FAIL lu_fwd_mem got=%b want=%b", fwd, 4'b1000);
        end
        total++;
        if (stall_cnt !== 32'd1) begin
            bad++; $display("FAIL lu_stall_cnt got=%0d want=1", stall_cnt);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        #1;
        total++;
        if (fwd !== 4'b0000) begin
            bad++; $display("FAIL b2b_x0 got=%b want=%b", fwd, 4'b0000);
        end
        step();
        set_id(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
        #1;
        total++;
        if (ctl !== 4'b0000) begin
            bad++; $display("FAIL b2b_nostall got=%b want=%b", ctl, 4'b0000);
        end
        total++;
        if (fwd !== 4'b0100) begin
            bad++; $display("FAIL b2b_fwd_ex got=%b want=%b", fwd, 4'b0100);
        end
        step();
        set_id(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0);
        #1;
        total++;
        if (fwd !== 4'b1001) begin
            bad++; $display("FAIL b2b_fwd_mem_ex got=%b want=%b", fwd, 4'b1001);
        end
        idle();
    endtask

    task automatic test_youngest();
        do_reset();
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        step();
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        step();
        set_id(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        total++;
        if (fwd !== 4'b0100) begin
            bad++; $display("FAIL yng_ex_over_wb got=%b want=%b", fwd, 4'b0100);
        end
        id_rs1_r_ena = 1'b0;
        #1;
        total++;
        if (fwd !== 4'b0000) begin
            bad++; $display("FAIL yng_rs1_off got=%b want=%b", fwd, 4'b0000);
        end
        id_rs1_r_ena = 1'b1;
        step();
        total++;
        if (fwd !== 4'b1000) begin
            bad++; $display("FAIL yng_mem got=%b want=%b", fwd, 4'b1000);
        end
        step();
        total++;
        if (fwd !== 4'b1100) begin
            bad++; $display("FAIL yng_wb got=%b want=%b", fwd, 4'b1100);
        end
        idle();
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0, 1'b0);
        ex_redirect = 1'b1;
        #1;
        total++;
        if (ctl !== 4'b0110) begin
            bad++; $display("FAIL rd_flush got=%b want=%b", ctl, 4'b0110);
        end
        step();
        ex_redirect = 1'b0;
        #1;
        total++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            bad++; $display("FAIL rd_cnt got=%0d/%0d want=1/0", flush_cnt, stall_cnt);
        end
        total++;
        if (ctl !== 4'b0000 || fwd !== 4'b1000) begin
            bad++; $display("FAIL rd_after got=%b/%b want=0000/1000", ctl, fwd);
        end
        idle();
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0, 1'b0);
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== 4'b1001 || stall_cnt !== 32'd0) begin
                bad++; $display("FAIL frz_hold[%0d] got=%b/%0d want=1001/0", i, ctl, stall_cnt);
            end
            step();
        end
        mem_busy = 1'b0;
        #1;
        total++;
        if (ctl !== 4'b1010 || fwd !== 4'b0000) begin
            bad++; $display("FAIL frz_release got=%b/%b want=1010/0000", ctl, fwd);
        end
        step();
        total++;
        if (ctl !== 4'b0000 || fwd !== 4'b1000 || stall_cnt !== 32'd1) begin
            bad++; $display("FAIL frz_after got=%b/%b/%0d want=0000/1000/1", ctl, fwd, stall_cnt);
        end
        idle();
    endtask

    task automatic test_csr();
        do_reset();
        set_id(1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl !== 4'b1010) begin
                bad++; $display("FAIL csr_stall[%0d] got=%b want=%b", i, ctl, 4'b1010);
            end
            step();
        end
        #1;
        total++;
        if (ctl !== 4'b0000 || stall_cnt !== 32'd3) begin
            bad++; $display("FAIL csr_release got=%b/%0d want=0000/3", ctl, stall_cnt);
        end
        total++;
        if (s_stall_cnt !== 2'b11) begin
            bad++; $display("FAIL sat_reach got=%b want=%b", s_stall_cnt, 2'b11);
        end
        step();
        set_id(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        total++;
        if (ctl !== 4'b1010) begin
            bad++; $display("FAIL csr_again got=%b want=%b", ctl, 4'b1010);
        end
        step();
        idle();
        #1;
        total++;
        if (stall_cnt !== 32'd4 || s_stall_cnt !== 2'b11) begin
            bad++; $display("FAIL sat_hold got=%0d/%b want=4/11", stall_cnt, s_stall_cnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_id(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        step();
        ex_redirect = 1'b0;
        step();
        set_id(1'b1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b0, 1'b0);
        #1;
        total++;
        if (ctl !== 4'b1010 || flush_cnt !== 32'd1) begin
            bad++; $display("FAIL mr_pre got=%b/%0d want=1010/1", ctl, flush_cnt);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (ctl !== 4'b0010 || fwd !== 4'b0000) begin
            bad++; $display("FAIL mr_ctl got=%b/%b want=0010/0000", ctl, fwd);
        end
        total++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            bad++; $display("FAIL mr_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        step();
        rst = 1'b1;
        #1;
        total++;
        if (ctl !== 4'b0000 || fwd !== 4'b0000) begin
            bad++; $display("FAIL mr_post got=%b/%b want=0000/0000", ctl, fwd);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_youngest();
        test_redirect();
        test_freeze();
        test_csr();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
